// File: rtl/rtz_serializer_if.sv
// Parallel-word input handshake plus serial-line and frame-status outputs of rtz_serializer.
// master drives words and clr_total; slave is the serializer.
interface rtz_serializer_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             clr_total;
   logic             data;
   logic             busy;
   logic             frame_start;
   logic             frame_done;
   logic [CW-1:0]    frame_ones;
   logic [3:0]       ones_total;

   modport master (
      output in_data, in_valid, clr_total,
      input  in_ready, data, busy, frame_start, frame_done, frame_ones, ones_total
   );

   modport slave (
      input  in_data, in_valid, clr_total,
      output in_ready, data, busy, frame_start, frame_done, frame_ones, ones_total
   );
endinterface

// File: rtl/rtz_serializer.sv
// FIFO-buffered MSB-first serializer with optional return-to-zero bits; first bit 2 edges after accept.
// Backpressure: in_ready drops only when the FIFO is full; the serial side never stalls.
module rtz_serializer #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 4,
   parameter int RTZ        = 1,
   parameter int GAP_CYCLES = 2
) (
   input logic          clk,
   input logic          reset,
   rtz_serializer_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam int NW = AW + 1;
   localparam int BW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, BIT, ZERO, GAP} state_t;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [NW-1:0]    count;
   logic             empty_q, full, push, pop;

   state_t           state, state_nx;
   logic [WIDTH-1:0] shreg, head;
   logic [BW-1:0]    bitcnt;
   logic [3:0]       gapcnt;
   logic [CW-1:0]    frm_pc, frame_ones_q;
   logic [3:0]       ones_q;
   logic             data_q, data_nx, start_q;
   logic             load, shift, done, last;

   function automatic logic [CW-1:0] popcnt(input logic [WIDTH-1:0] w);
      logic [CW-1:0] n;
      n = '0;
      for (int i = 0; i < WIDTH; i++) n = n + CW'(w[i]);
      return n;
   endfunction

   assign full            = (count == NW'(DEPTH));
   assign push            = bus.in_valid && !full;
   assign pop             = load;
   assign head            = mem[rd_ptr];
   assign last            = (bitcnt == '0);

   assign bus.in_ready    = !full;
   assign bus.busy        = (state != IDLE) || (count != '0);
   assign bus.data        = data_q;
   assign bus.frame_start = start_q;
   assign bus.frame_done  = done;
   assign bus.frame_ones  = frame_ones_q;
   assign bus.ones_total  = ones_q;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.in_data;
   end

   // empty_q lags the count by one edge, which gives the two-edge accept-to-first-bit latency
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         empty_q <= 1'b1;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count   <= count + NW'(push) - NW'(pop);
         empty_q <= (count == '0);
      end
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      shift    = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: if (!empty_q) begin
            load     = 1'b1;
            state_nx = BIT;
         end
         BIT: begin
            if (RTZ != 0) begin
               state_nx = ZERO;
            end else if (!last) begin
               shift = 1'b1;
            end else begin
               done     = 1'b1;
               state_nx = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
         end
         ZERO: begin
            if (!last) begin
               shift    = 1'b1;
               state_nx = BIT;
            end else begin
               done     = 1'b1;
               state_nx = (GAP_CYCLES > 0) ? GAP : IDLE;
            end
         end
         GAP: if (gapcnt == '0) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      data_nx = load ? head[WIDTH-1] : (shift ? shreg[WIDTH-2] : 1'b0);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         data_q       <= 1'b0;
         start_q      <= 1'b0;
         shreg        <= '0;
         bitcnt       <= '0;
         gapcnt       <= '0;
         frm_pc       <= '0;
         frame_ones_q <= '0;
         ones_q       <= '0;
      end else begin
         state   <= state_nx;
         data_q  <= data_nx;
         start_q <= load;
         if (load) begin
            shreg  <= head;
            bitcnt <= BW'(WIDTH - 1);
            frm_pc <= popcnt(head);
         end else if (shift) begin
            shreg  <= shreg << 1;
            bitcnt <= bitcnt - 1'b1;
         end
         if (done)               gapcnt <= 4'(GAP_CYCLES - 1);
         else if (state == GAP)  gapcnt <= gapcnt - 1'b1;
         // clear-then-add when clr_total coincides with frame_done
         if (done) begin
            frame_ones_q <= frm_pc;
            ones_q       <= (bus.clr_total ? 4'd0 : ones_q) + 4'(frm_pc);
         end else if (bus.clr_total) begin
            ones_q <= 4'd0;
         end
      end
   end
endmodule

// File: tb/tb_rtz_serializer.sv
// Bench for rtz_serializer: an RTZ/gap instance and an NRZ/no-gap instance checked against a frame-level model.
module tb_rtz_serializer;
   typedef struct {
      logic [7:0] w;
      int         t;
   } ent_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   rtz_serializer_if #(.WIDTH(8)) ifa ();
   rtz_serializer_if #(.WIDTH(8)) ifb ();

   rtz_serializer #(.WIDTH(8), .DEPTH(4), .RTZ(1), .GAP_CYCLES(2)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa));
   rtz_serializer #(.WIDTH(8), .DEPTH(4), .RTZ(0), .GAP_CYCLES(0)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb));

   int checks = 0;
   int errors = 0;

   // model state, index 0 = dut_a, 1 = dut_b
   ent_t       qa[$];
   ent_t       qb[$];
   int         cyc = 0;
   int         ph[2]     = '{-1, -1};
   logic [7:0] cur[2]    = '{8'h00, 8'h00};
   int         tot[2]    = '{0, 0};
   int         lst[2]    = '{0, 0};
   int         frames[2] = '{0, 0};
   int         pushed[2] = '{0, 0};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_bit(input logic [7:0] w, input int p, input int rtz);
      if (rtz != 0) return (p % 2 == 1) ? 1'b0 : w[7 - p / 2];
      return w[7 - p];
   endfunction

   task automatic mon(input int id, input int rtz, input int gap, input logic avail, input int qsz,
                      input logic rst, input logic fs, input logic dat, input logic fd,
                      input logic rdy, input logic bsy, input logic [3:0] fo,
                      input logic [3:0] ot, input logic clr);
      int    len;
      string nm;
      len = 8 * (1 + rtz);
      nm  = (id == 0) ? "a" : "b";
      if (!rst) begin
         ph[id] = -1; tot[id] = 0; lst[id] = 0;
         chk({nm, "_rst_data"}, dat, 0);
         chk({nm, "_rst_done"}, fd, 0);
         chk({nm, "_rst_total"}, ot, 0);
         chk({nm, "_rst_ones"}, fo, 0);
         chk({nm, "_rst_ready"}, rdy, 1);
         chk({nm, "_rst_busy"}, bsy, 0);
         return;
      end
      chk({nm, "_ones_total"}, ot, tot[id]);
      chk({nm, "_frame_ones"}, fo, lst[id]);
      if (ph[id] < 0) begin
         chk({nm, "_start_when_avail"}, fs, avail);
         if (fs) ph[id] = 0;
      end else begin
         chk({nm, "_no_start_in_frame"}, fs, 0);
      end
      chk({nm, "_in_ready"}, rdy, qsz < 4);
      chk({nm, "_busy"}, bsy, (ph[id] >= 0 && ph[id] < len + gap) || qsz != 0);
      if (ph[id] < 0) begin
         chk({nm, "_idle_data"}, dat, 0);
         chk({nm, "_idle_done"}, fd, 0);
         if (clr) tot[id] = 0;
      end else begin
         chk({nm, "_data"}, dat, (ph[id] < len) ? exp_bit(cur[id], ph[id], rtz) : 1'b0);
         chk({nm, "_frame_done"}, fd, ph[id] == len - 1);
         if (ph[id] == len - 1) begin
            tot[id] = ((clr ? 0 : tot[id]) + $countones(cur[id])) % 16;
            lst[id] = $countones(cur[id]);
            frames[id]++;
         end else if (clr) begin
            tot[id] = 0;
         end
         ph[id] = (ph[id] == len + gap) ? -1 : ph[id] + 1;
      end
   endtask

   always @(posedge clk) begin
      ent_t e;
      cyc = cyc + 1;
      if (reset && ifa.in_valid && ifa.in_ready) begin e.w = ifa.in_data; e.t = cyc; qa.push_back(e); end
      if (reset && ifb.in_valid && ifb.in_ready) begin e.w = ifb.in_data; e.t = cyc; qb.push_back(e); end
   end

   always @(negedge clk) begin
      logic av_a, av_b;
      if (!reset) begin qa.delete(); qb.delete(); end
      av_a = (qa.size() > 0) && (cyc >= qa[0].t + 2);
      av_b = (qb.size() > 0) && (cyc >= qb[0].t + 2);
      if (reset && ph[0] < 0 && ifa.frame_start && qa.size() > 0) cur[0] = qa.pop_front().w;
      if (reset && ph[1] < 0 && ifb.frame_start && qb.size() > 0) cur[1] = qb.pop_front().w;
      mon(0, 1, 2, av_a, qa.size(), reset, ifa.frame_start, ifa.data, ifa.frame_done,
          ifa.in_ready, ifa.busy, ifa.frame_ones, ifa.ones_total, ifa.clr_total);
      mon(1, 0, 0, av_b, qb.size(), reset, ifb.frame_start, ifb.data, ifb.frame_done,
          ifb.in_ready, ifb.busy, ifb.frame_ones, ifb.ones_total, ifb.clr_total);
   end

   task automatic push(input int id, input logic [7:0] w, output int stalls);
      logic rdy;
      stalls = 0;
      if (id == 0) begin ifa.in_data = w; ifa.in_valid = 1'b1; end
      else         begin ifb.in_data = w; ifb.in_valid = 1'b1; end
      while (stalls < 200) begin
         @(negedge clk);
         rdy = (id == 0) ? ifa.in_ready : ifb.in_ready;
         @(posedge clk);
         if (rdy) break;
         stalls++;
      end
      #1;
      ifa.in_valid = 1'b0;
      ifb.in_valid = 1'b0;
      chk("push_accepted", stalls < 200, 1);
      pushed[id]++;
   endtask

   task automatic wait_fs(input int id);
      int n;
      for (n = 0; n < 300; n++) begin
         @(posedge clk); #1;
         if ((id == 0) ? ifa.frame_start : ifb.frame_start) break;
      end
      chk("frame_start_seen", n < 300, 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (n < 1000 && !(ph[0] < 0 && ph[1] < 0 && !ifa.busy && !ifb.busy)) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", n < 1000, 1);
      @(posedge clk); #1;
   endtask

   // accept into an empty idle serializer, then check the first bit lands exactly two edges later
   task automatic lat_a(input logic [7:0] w);
      int st;
      push(0, w, st);
      chk("lat_edge0_start", ifa.frame_start, 0);
      @(posedge clk); #1;
      chk("lat_edge1_start", ifa.frame_start, 0);
      chk("lat_edge1_data", ifa.data, 0);
      @(posedge clk); #1;
      chk("lat_edge2_start", ifa.frame_start, 1);
      chk("lat_edge2_data", ifa.data, w[7]);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int st, stalls;
      ifa.in_data = '0; ifa.in_valid = 1'b0; ifa.clr_total = 1'b0;
      ifb.in_data = '0; ifb.in_valid = 1'b0; ifb.clr_total = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_data", ifa.data, 0);
      chk("reset_in_ready", ifa.in_ready, 1);
      chk("reset_busy", ifa.busy, 0);
      chk("reset_total", ifb.ones_total, 0);
      reset = 1'b1;
      @(posedge clk); #1;

      // single RTZ frame with gap
      lat_a(8'hA5);
      wait_idle();
      chk("a5_frame_ones", ifa.frame_ones, 4);
      chk("a5_total", ifa.ones_total, 4);

      // NRZ back-to-back frames
      push(1, 8'hC3, st);
      push(1, 8'h81, st);
      wait_idle();
      chk("b_frame_ones_81", ifb.frame_ones, 2);
      chk("b_total_6", ifb.ones_total, 6);

      // six words with valid held: the sixth must wait for space
      stalls = 0;
      for (int i = 0; i < 6; i++) begin
         push(1, 8'($urandom), st);
         stalls += st;
      end
      chk("b_backpressure_seen", stalls > 0, 1);
      wait_idle();

      // clr_total alone, then 0xFF twice wraps the mod-16 total
      ifa.clr_total = 1'b1;
      @(posedge clk); #1;
      ifa.clr_total = 1'b0;
      chk("a_clr_alone", ifa.ones_total, 0);
      push(0, 8'hFF, st);
      push(0, 8'hFF, st);
      wait_idle();
      chk("a_ff_wrap", ifa.ones_total, 0);

      // clr_total coinciding with the second frame_done: clear then add
      push(0, 8'hFF, st);
      push(0, 8'hFF, st);
      wait_fs(0);
      wait_fs(0);
      repeat (15) @(posedge clk);
      #1;
      chk("a_done_for_clr", ifa.frame_done, 1);
      ifa.clr_total = 1'b1;
      @(posedge clk); #1;
      ifa.clr_total = 1'b0;
      chk("a_clr_with_done", ifa.ones_total, 8);
      wait_idle();

      // reset on the third bit of 0xFF aborts the frame
      push(0, 8'hFF, st);
      wait_fs(0);
      repeat (4) @(posedge clk);
      #1;
      chk("a_third_bit", ifa.data, 1);
      reset = 1'b0;
      #1;
      chk("a_abort_data", ifa.data, 0);
      chk("a_abort_done", ifa.frame_done, 0);
      chk("a_abort_ready", ifa.in_ready, 1);
      chk("a_abort_total", ifa.ones_total, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      lat_a(8'h6E);
      wait_idle();
      chk("a_after_reset_ones", ifa.frame_ones, 5);

      // randomized traffic on both instances
      for (int i = 0; i < 12; i++) begin
         ifb.clr_total = ($urandom_range(0, 3) == 0);
         push(i % 2, 8'($urandom), st);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         ifb.clr_total = 1'b0;
      end
      wait_idle();

      chk("a_frames_complete", frames[0], pushed[0] - 1);
      chk("b_frames_complete", frames[1], pushed[1]);
      chk("queues_drained", qa.size() + qb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
